// File: rtl/pitch_game_pkg.sv
// Shared types and default constants for the
// button conditioner and its per-channel logic.
package pitch_game_pkg;

  typedef enum logic [1:0] {
    IDLE,
    HELD,
    REPEAT
  } ch_state_t;

  localparam int DEF_N_CH         = 2;
  localparam int DEF_SYNC_STAGES  = 2;
  localparam int DEF_DEBOUNCE_CYC = 250000;
  localparam int DEF_REPEAT_DELAY = 25000000;
  localparam int DEF_REPEAT_RATE  = 5000000;

endpackage

// File: rtl/button_channel.sv
// One button: synchroniser, debouncer and
// press / release / auto-repeat pulse generator.
module button_channel
  import pitch_game_pkg::*;
#(
  parameter int SYNC_STAGES  = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
  parameter int REPEAT_DELAY = DEF_REPEAT_DELAY,
  parameter int REPEAT_RATE  = DEF_REPEAT_RATE
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_btn_n,
  input  logic i_rpt_en,
  output logic o_level,
  output logic o_press,
  output logic o_release
);

  localparam int DBW  = $clog2(DEBOUNCE_CYC + 1);
  localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ?
                        REPEAT_DELAY : REPEAT_RATE;
  localparam int RPW  = $clog2(RMAX + 1);

  localparam logic [DBW-1:0] DB_LAST  = DBW'(DEBOUNCE_CYC - 1);
  localparam logic [DBW-1:0] DB_MAX   = DBW'(DEBOUNCE_CYC);
  localparam logic [RPW-1:0] DLY_LAST = RPW'(REPEAT_DELAY - 1);
  localparam logic [RPW-1:0] RT_LAST  = RPW'(REPEAT_RATE - 1);
  localparam logic [RPW-1:0] RP_MAX   = RPW'(RMAX);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [DBW-1:0]         r_db_cnt;
  logic                   r_level;
  logic                   r_press;
  logic                   r_release;
  ch_state_t              r_state;
  ch_state_t              w_state_nxt;
  logic [RPW-1:0]         r_rpt_cnt;
  logic [RPW-1:0]         w_rpt_cnt_nxt;
  logic [RPW-1:0]         w_rpt_inc;
  logic                   w_s;
  logic                   w_diff;
  logic                   w_toggle;
  logic                   w_rise;
  logic                   w_fall;
  logic                   w_rpt_pulse;

  assign w_s      = ~r_sync[SYNC_STAGES-1];
  assign w_diff   = w_s ^ r_level;
  assign w_toggle = w_diff && (r_db_cnt == DB_LAST);
  assign w_rise   = w_toggle && !r_level;
  assign w_fall   = w_toggle && r_level;

  assign w_rpt_inc = (r_rpt_cnt == RP_MAX) ?
                     r_rpt_cnt : r_rpt_cnt + 1'b1;

  // Synchroniser idles at 1 so reset looks released.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync   <= '1;
      r_db_cnt <= '0;
      r_level  <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_btn_n};
      if (!w_diff || w_toggle)
        r_db_cnt <= '0;
      else if (r_db_cnt != DB_MAX)
        r_db_cnt <= r_db_cnt + 1'b1;
      if (w_toggle)
        r_level <= ~r_level;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_rpt_cnt_nxt = '0;
    w_rpt_pulse   = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_rise)
          w_state_nxt = HELD;
      end
      HELD: begin
        if (w_fall) begin
          w_state_nxt = IDLE;
        end else if (i_rpt_en) begin
          if (r_rpt_cnt == DLY_LAST) begin
            w_rpt_pulse = 1'b1;
            w_state_nxt = REPEAT;
          end else begin
            w_rpt_cnt_nxt = w_rpt_inc;
          end
        end
      end
      REPEAT: begin
        // A coinciding fall wins over a repeat pulse.
        if (w_fall) begin
          w_state_nxt = IDLE;
        end else if (!i_rpt_en) begin
          w_state_nxt = HELD;
        end else if (r_rpt_cnt == RT_LAST) begin
          w_rpt_pulse = 1'b1;
        end else begin
          w_rpt_cnt_nxt = w_rpt_inc;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= IDLE;
      r_rpt_cnt <= '0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_rpt_cnt <= w_rpt_cnt_nxt;
      r_press   <= w_rise | w_rpt_pulse;
      r_release <= w_fall;
    end
  end

  assign o_level   = r_level;
  assign o_press   = r_press;
  assign o_release = r_release;

endmodule

// File: rtl/button_conditioner.sv
// Multi-channel button conditioner: one
// independent button_channel per button.
module button_conditioner
  import pitch_game_pkg::*;
#(
  parameter int N_CH         = DEF_N_CH,
  parameter int SYNC_STAGES  = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
  parameter int REPEAT_DELAY = DEF_REPEAT_DELAY,
  parameter int REPEAT_RATE  = DEF_REPEAT_RATE
) (
  input  logic            clk,
  input  logic            resetNot,
  input  logic [N_CH-1:0] btn_n,
  input  logic [N_CH-1:0] rpt_en,
  output logic [N_CH-1:0] level,
  output logic [N_CH-1:0] press,
  output logic [N_CH-1:0] release_o
);

  if (N_CH < 1 || N_CH > 16) begin : g_bad_nch
    $error("N_CH must be 1..16");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("SYNC_STAGES must be >= 2");
  end
  if (DEBOUNCE_CYC < 1) begin : g_bad_db
    $error("DEBOUNCE_CYC must be >= 1");
  end
  if (REPEAT_DELAY < 1) begin : g_bad_dly
    $error("REPEAT_DELAY must be >= 1");
  end
  if (REPEAT_RATE < 1) begin : g_bad_rate
    $error("REPEAT_RATE must be >= 1");
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    button_channel #(
      .SYNC_STAGES (SYNC_STAGES),
      .DEBOUNCE_CYC(DEBOUNCE_CYC),
      .REPEAT_DELAY(REPEAT_DELAY),
      .REPEAT_RATE (REPEAT_RATE)
    ) u_ch (
      .i_clk    (clk),
      .i_rst_n  (resetNot),
      .i_btn_n  (btn_n[g]),
      .i_rpt_en (rpt_en[g]),
      .o_level  (level[g]),
      .o_press  (press[g]),
      .o_release(release_o[g])
    );
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed table-driven bench for button_conditioner
// with short debounce / repeat parameters.
module tb_button_conditioner;

  logic       clk = 1'b0;
  logic       resetNot;
  logic [1:0] btn_n;
  logic [1:0] rpt_en;
  logic [1:0] level;
  logic [1:0] press;
  logic [1:0] release_o;

  int checks = 0;
  int errors = 0;
  int split  = 0;

  typedef struct {
    int         n;
    logic       rst;
    logic [1:0] btn;
    logic [1:0] rpt;
    logic [1:0] lvl;
    logic [1:0] prs;
    logic [1:0] rel;
  } vec_t;

  vec_t tbl[$];

  always #5 clk = ~clk;

  button_conditioner #(
    .N_CH        (2),
    .SYNC_STAGES (2),
    .DEBOUNCE_CYC(4),
    .REPEAT_DELAY(10),
    .REPEAT_RATE (3)
  ) dut (
    .clk      (clk),
    .resetNot (resetNot),
    .btn_n    (btn_n),
    .rpt_en   (rpt_en),
    .level    (level),
    .press    (press),
    .release_o(release_o)
  );

  task automatic add(input int n, input logic rst,
                     input logic [1:0] btn, input logic [1:0] rpt,
                     input logic [1:0] lvl, input logic [1:0] prs,
                     input logic [1:0] rel);
    vec_t v;
    v.n = n;
    v.rst = rst;
    v.btn = btn;
    v.rpt = rpt;
    v.lvl = lvl;
    v.prs = prs;
    v.rel = rel;
    tbl.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [1:0] act,
                     input logic [1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %b want %b", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string nm, input logic [1:0] l,
                         input logic [1:0] p, input logic [1:0] r);
    chk({nm, " level"}, level, l);
    chk({nm, " press"}, press, p);
    chk({nm, " release"}, release_o, r);
  endtask

  task automatic run(input int lo, input int hi);
    for (int i = lo; i < hi; i++) begin
      resetNot = tbl[i].rst;
      btn_n    = tbl[i].btn;
      rpt_en   = tbl[i].rpt;
      for (int k = 0; k < tbl[i].n; k++) begin
        step();
        chk_all($sformatf("row%0d.%0d", i, k),
                tbl[i].lvl, tbl[i].prs, tbl[i].rel);
      end
    end
  endtask

  initial begin
    resetNot = 1'b0;
    btn_n    = 2'b11;
    rpt_en   = 2'b00;

    // basic press on ch0, glitch and minimum press on ch1
    add(3, 1, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00);
    add(5, 1, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00);
    add(1, 1, 2'b10, 2'b00, 2'b01, 2'b01, 2'b00);
    add(2, 1, 2'b10, 2'b00, 2'b01, 2'b00, 2'b00);
    add(3, 1, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00);
    add(6, 1, 2'b10, 2'b00, 2'b01, 2'b00, 2'b00);
    add(4, 1, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00);
    add(1, 1, 2'b10, 2'b00, 2'b01, 2'b00, 2'b00);
    add(1, 1, 2'b10, 2'b00, 2'b11, 2'b10, 2'b00);
    add(3, 1, 2'b10, 2'b00, 2'b11, 2'b00, 2'b00);
    add(1, 1, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10);
    add(2, 1, 2'b10, 2'b00, 2'b01, 2'b00, 2'b00);
    add(5, 1, 2'b11, 2'b00, 2'b01, 2'b00, 2'b00);
    add(1, 1, 2'b11, 2'b00, 2'b00, 2'b00, 2'b01);
    add(3, 1, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00);

    // auto-repeat on ch0, release coincides with repeat
    add(5, 1, 2'b10, 2'b01, 2'b00, 2'b00, 2'b00);
    add(1, 1, 2'b10, 2'b01, 2'b01, 2'b01, 2'b00);
    add(9, 1, 2'b10, 2'b01, 2'b01, 2'b00, 2'b00);
    add(1, 1, 2'b10, 2'b01, 2'b01, 2'b01, 2'b00);
    for (int j = 0; j < 4; j++) begin
      add(2, 1, 2'b10, 2'b01, 2'b01, 2'b00, 2'b00);
      add(1, 1, 2'b10, 2'b01, 2'b01, 2'b01, 2'b00);
    end
    add(2, 1, 2'b11, 2'b01, 2'b01, 2'b00, 2'b00);
    add(1, 1, 2'b11, 2'b01, 2'b01, 2'b01, 2'b00);
    add(2, 1, 2'b11, 2'b01, 2'b01, 2'b00, 2'b00);
    add(1, 1, 2'b11, 2'b01, 2'b00, 2'b00, 2'b01);
    add(4, 1, 2'b11, 2'b01, 2'b00, 2'b00, 2'b00);

    // both channels, rpt_en drop and re-assert on ch0
    add(5, 1, 2'b00, 2'b11, 2'b00, 2'b00, 2'b00);
    add(1, 1, 2'b00, 2'b11, 2'b11, 2'b11, 2'b00);
    add(9, 1, 2'b00, 2'b11, 2'b11, 2'b00, 2'b00);
    add(1, 1, 2'b00, 2'b11, 2'b11, 2'b11, 2'b00);
    add(2, 1, 2'b00, 2'b11, 2'b11, 2'b00, 2'b00);
    add(1, 1, 2'b00, 2'b11, 2'b11, 2'b11, 2'b00);
    add(1, 1, 2'b00, 2'b11, 2'b11, 2'b00, 2'b00);
    add(1, 1, 2'b00, 2'b10, 2'b11, 2'b00, 2'b00);
    add(1, 1, 2'b00, 2'b10, 2'b11, 2'b10, 2'b00);
    add(2, 1, 2'b00, 2'b10, 2'b11, 2'b00, 2'b00);
    add(1, 1, 2'b00, 2'b10, 2'b11, 2'b10, 2'b00);
    add(2, 1, 2'b00, 2'b10, 2'b11, 2'b00, 2'b00);
    add(1, 1, 2'b00, 2'b11, 2'b11, 2'b10, 2'b00);
    add(2, 1, 2'b00, 2'b11, 2'b11, 2'b00, 2'b00);
    add(1, 1, 2'b00, 2'b11, 2'b11, 2'b10, 2'b00);
    add(2, 1, 2'b00, 2'b11, 2'b11, 2'b00, 2'b00);
    add(1, 1, 2'b00, 2'b11, 2'b11, 2'b10, 2'b00);
    add(2, 1, 2'b00, 2'b11, 2'b11, 2'b00, 2'b00);
    add(1, 1, 2'b00, 2'b11, 2'b11, 2'b11, 2'b00);
    split = tbl.size();

    // reset held mid-press, then full latency again
    add(2, 0, 2'b00, 2'b11, 2'b00, 2'b00, 2'b00);
    add(5, 1, 2'b00, 2'b11, 2'b00, 2'b00, 2'b00);
    add(1, 1, 2'b00, 2'b11, 2'b11, 2'b11, 2'b00);
    add(1, 1, 2'b00, 2'b11, 2'b11, 2'b00, 2'b00);
    add(5, 1, 2'b11, 2'b00, 2'b11, 2'b00, 2'b00);
    add(1, 1, 2'b11, 2'b00, 2'b00, 2'b00, 2'b11);
    add(2, 1, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00);

    for (int k = 0; k < 2; k++) begin
      step();
      chk_all($sformatf("reset%0d", k), 2'b00, 2'b00, 2'b00);
    end
    btn_n = 2'b00;
    for (int k = 0; k < 3; k++) begin
      step();
      chk_all($sformatf("reset_btn%0d", k), 2'b00, 2'b00, 2'b00);
    end
    btn_n = 2'b11;

    run(0, split);

    resetNot = 1'b0;
    #2;
    chk_all("async_reset", 2'b00, 2'b00, 2'b00);

    run(split, tbl.size());

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
